// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for pipe_stage_skid: occupancy states, perf counter width and
// per-stage control bundles whose NOP constants serve as CTRL_BUBBLE values.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam int PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_PC4  = 2'd3
  } wb_sel_e;

  typedef enum logic [3:0] {
    ALUOP_NONE = 4'd0,
    ALUOP_ADD  = 4'd1,
    ALUOP_SUB  = 4'd2,
    ALUOP_AND  = 4'd3,
    ALUOP_OR   = 4'd4,
    ALUOP_XOR  = 4'd5,
    ALUOP_SLT  = 4'd6,
    ALUOP_SLL  = 4'd7,
    ALUOP_SRL  = 4'd8,
    ALUOP_SRA  = 4'd9
  } alu_op_e;

  // IF/ID: only the branch-prediction hint travels as control
  localparam int IFID_CTRL_W = 1;
  localparam int IFID_DATA_W = 64;
  localparam logic [IFID_CTRL_W-1:0] IFID_CTRL_NOP = 1'b0;

  typedef struct packed {
    wb_sel_e    wb_sel;
    alu_op_e    alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic [4:0] rsvd;
  } idex_ctrl_t;

  localparam int IDEX_CTRL_W = $bits(idex_ctrl_t);
  localparam int IDEX_DATA_W = 192;
  localparam idex_ctrl_t IDEX_CTRL_NOP = '{
    wb_sel: WB_NONE, alu_op: ALUOP_NONE, mem_read: 1'b0, mem_write: 1'b0,
    reg_write: 1'b0, branch: 1'b0, jump: 1'b0, rsvd: 5'd0
  };

  typedef struct packed {
    wb_sel_e    wb_sel;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [2:0] rsvd;
  } exmem_ctrl_t;

  localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);
  localparam int EXMEM_DATA_W = 96;
  localparam exmem_ctrl_t EXMEM_CTRL_NOP = '{
    wb_sel: WB_NONE, mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0, rsvd: 3'd0
  };

  typedef struct packed {
    wb_sel_e    wb_sel;
    logic       reg_write;
    logic [4:0] rsvd;
  } memwb_ctrl_t;

  localparam int MEMWB_CTRL_W = $bits(memwb_ctrl_t);
  localparam int MEMWB_DATA_W = 96;
  localparam memwb_ctrl_t MEMWB_CTRL_NOP = '{wb_sel: WB_NONE, reg_write: 1'b0, rsvd: 5'd0};

  function automatic logic [1:0] state_occ(pipe_state_e s);
    case (s)
      PS_BUSY: state_occ = 2'd1;
      PS_FULL: state_occ = 2'd2;
      default: state_occ = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating stall/bubble counter pair for pipe_stage_skid.
// Only instantiated when PIPE_STAGE_PERF_EN is defined.
module pipe_perf_cnt
  import pipe_stage_skid_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_inc,
  input  logic                  bubble_inc,
  output logic [PERF_CNT_W-1:0] stall_cnt_o,
  output logic [PERF_CNT_W-1:0] bubble_cnt_o
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (stall_inc && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + PERF_CNT_W'(1);
      if (bubble_inc && (bubble_cnt_o != '1))
        bubble_cnt_o <= bubble_cnt_o + PERF_CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with a 2-entry skid buffer so up_ready_o is a flop.
// Define PIPE_STAGE_PERF_EN to add the perf_stall_o / perf_bubble_o counters.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                CTRL_W      = 16,
  parameter int                DATA_W      = 192,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter bit                CLEAR_DATA  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [CTRL_W-1:0] up_ctrl_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [CTRL_W-1:0] dn_ctrl_o,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occ_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_o,
  output logic [PERF_CNT_W-1:0] perf_bubble_o
`endif
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              up_ready_q, dn_valid_q;
  logic [1:0]        occ_q;
  logic              up_fire, dn_fire;

  assign up_fire = up_valid_i & up_ready_q;
  assign dn_fire = dn_valid_q & dn_ready_i;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      state_d     = PS_EMPTY;
      main_ctrl_d = CTRL_BUBBLE;
      skid_ctrl_d = CTRL_BUBBLE;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (up_fire) begin
            main_ctrl_d = up_ctrl_i;
            main_data_d = up_data_i;
            state_d     = PS_BUSY;
          end
        end
        PS_BUSY: begin
          if (up_fire && dn_fire) begin
            main_ctrl_d = up_ctrl_i;
            main_data_d = up_data_i;
          end else if (up_fire) begin
            skid_ctrl_d = up_ctrl_i;
            skid_data_d = up_data_i;
            state_d     = PS_FULL;
          end else if (dn_fire) begin
            main_ctrl_d = CTRL_BUBBLE;
            if (CLEAR_DATA) main_data_d = '0;
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          // up_ready is low here, so only the downstream side can move
          if (dn_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = CTRL_BUBBLE;
            if (CLEAR_DATA) skid_data_d = '0;
            state_d = PS_BUSY;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PS_EMPTY;
      main_ctrl_q <= CTRL_BUBBLE;
      main_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      up_ready_q  <= 1'b1;
      dn_valid_q  <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      up_ready_q  <= (state_d != PS_FULL);
      dn_valid_q  <= (state_d != PS_EMPTY);
      occ_q       <= state_occ(state_d);
    end
  end

  assign up_ready_o = up_ready_q;
  assign dn_valid_o = dn_valid_q;
  assign dn_ctrl_o  = main_ctrl_q;
  assign dn_data_o  = main_data_q;
  assign occ_o      = occ_q;

`ifdef PIPE_STAGE_PERF_EN
  logic flush_kill;
  // an entry leaving downstream in the flush cycle was consumed, not killed
  assign flush_kill = flush_i & ((state_q == PS_FULL) | ((state_q == PS_BUSY) & ~dn_fire));

  pipe_perf_cnt u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_inc    (dn_valid_q & ~dn_ready_i),
    .bubble_inc   (~dn_valid_q | flush_kill),
    .stall_cnt_o  (perf_stall_o),
    .bubble_cnt_o (perf_bubble_o)
  );
`endif

endmodule
